// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
//   Oversampled SPI (mode 0) slave that owns the expander's configuration
//   register bank. The SPI pins are synchronised into clk, 16-bit frames
//   {RW, addr[6:0], data[7:0]} are assembled MSB first, and each complete
//   frame either writes one register or reads one back on spi_miso.
//
// Ports
//   clk        in   internal clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset (deasserted synchronously)
//   spi_sck    in   SPI clock, mode 0, at most clk/8
//   spi_en     in   frame enable, active high
//   spi_mosi   in   serial data in, MSB first
//   spi_miso   out  serial read-back data, changes after SCK falling edges
//   regs_flat  out  register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  out  one-cycle pulse when a register is written
//   wr_addr    out  address of the last write
//   frame_err  out  one-cycle pulse on a malformed or out-of-range frame
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
  parameter int NREGS       = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_sck,
  input  logic                      spi_en,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [NREGS*DATA_W-1:0]   regs_flat,
  output logic                      wr_strobe,
  output logic [6:0]                wr_addr,
  output logic                      frame_err
);

  localparam int         AW       = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] CNT_ADDR = 5'd8;
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_MAX  = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHECK
  } state_e;

  // Bit counter saturates one past a full frame so that any overlong
  // frame is still distinguishable from a correct one.
  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 5'd1;
  endfunction

  function automatic logic addr_ok(input logic [6:0] a);
    return int'({25'd0, a}) < NREGS;
  endfunction

  // Reset: asserts immediately, releases on a clock edge
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Pin synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sck_sync_q, en_sync_q, mosi_sync_q;
  logic                   sck_prev_q, en_prev_q;
  logic                   sck_s, en_s, mosi_s;
  logic                   sck_rise, sck_fall, en_rise, en_fall;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sck_sync_q  <= '0;
      en_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      en_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], spi_en};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
      en_prev_q   <= en_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign en_rise  = en_s & ~en_prev_q;
  assign en_fall  = ~en_s & en_prev_q;

  // Frame FSM and datapath
  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d, cnt_nxt;
  logic [15:0] shift_q, shift_d, shift_nxt;
  logic [7:0]  tx_q, tx_d;
  logic        rd_q, rd_d;
  logic        miso_q, miso_d;
  logic        pend_q, pend_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        frame_err_q, frame_err_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic        wr_en;
  logic [6:0]  rd_addr;
  logic [DATA_W-1:0] regs_q [NREGS];

  assign shift_nxt = {shift_q[14:0], mosi_s};
  assign cnt_nxt   = sat_inc(bit_cnt_q);
  assign rd_addr   = shift_nxt[6:0];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    miso_d      = miso_q;
    pend_d      = pend_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (en_rise || pend_q) begin
          state_d   = S_ADDR;
          bit_cnt_d = '0;
          shift_d   = '0;
          rd_d      = 1'b0;
          pend_d    = 1'b0;
        end
      end

      S_ADDR: begin
        if (sck_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = cnt_nxt;
          if (cnt_nxt == CNT_ADDR) begin
            // RW and address are complete: preload the read-back byte now
            // so the first data bit can leave on the very next SCK fall.
            state_d = S_DATA;
            rd_d    = shift_nxt[7];
            tx_d    = addr_ok(rd_addr) ? regs_q[rd_addr[AW-1:0]] : 8'h00;
          end
        end
        // A coincident final SCK edge is captured above before the check.
        if (en_fall) state_d = S_CHECK;
      end

      S_DATA: begin
        if (sck_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = cnt_nxt;
        end
        if (rd_q && sck_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        if (en_fall) state_d = S_CHECK;
      end

      S_CHECK: begin
        miso_d  = 1'b0;
        state_d = S_IDLE;
        // A new frame starting during the check is remembered, not dropped.
        if (en_rise) pend_d = 1'b1;
        if (bit_cnt_q == CNT_FULL && addr_ok(shift_q[14:8])) begin
          if (!shift_q[15]) begin
            wr_en       = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = shift_q[14:8];
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      pend_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      miso_q      <= miso_d;
      pend_q      <= pend_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // Register bank, written only from the check state
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[shift_q[8 +: AW]] <= shift_q[DATA_W-1:0];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign spi_miso  = miso_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Oversampled SPI slave frame controller that sequences the expander's configuration register file.
- SPI pins are synchronised into the internal clock domain, 16-bit frames are assembled, and addressed writes or read-backs of the 8x8 register bank are performed.
- It owns the register bank and exposes it flat to the RGB/PWM channel logic.
- It replaces the split-clock capture path with a single-clock, glitch-safe controller.

Parameters:
- NREGS, 8, number of 8-bit registers (power of two, 2..128).
- DATA_W, 8, register width (fixed 8 for frame format).
- SYNC_STAGES, 2, synchroniser depth on spi_sck/spi_en/spi_mosi (>=2).

Ports:
- clk  in  1  internal oscillator clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock, mode 0, max frequency clk/8.
- spi_en  in  1  frame enable, active high.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out (read-back).
- regs_flat  out  NREGS*DATA_W  register bank; reg i at bits [i*8+7:i*8].
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  7  address of last write, valid with wr_strobe.
- frame_err  out  1  one-cycle pulse on malformed or out-of-range frame.

Behaviour:
- Reset (async assert, sync deassert internally): all registers 0x00, spi_miso 0, wr_strobe 0, wr_addr 0, frame_err 0, FSM IDLE, bit_cnt 0, shift register 0.
- Synchronisers: SYNC_STAGES flops per input. Edges are detected on the synchronised signals only (sck_rise, sck_fall, en_rise, en_fall).
- Frame format, 16 bits:
  - bit15 = RW (1 = read).
  - bits14:8 = address.
  - bits7:0 = write data (ignored for reads).
- bit_cnt: 5 bits, increments on each sck_rise while in a frame, saturates at 17.
- FSM states:
  - IDLE: en_rise -> ADDR; clear bit_cnt and shift register.
  - ADDR: shift mosi on sck_rise. When bit_cnt reaches 8 -> DATA. For reads, the addressed register is latched into the tx shift register at this point; an address >= NREGS latches 0x00.
  - DATA: shift mosi on sck_rise. For reads, spi_miso updates on sck_fall with the next tx bit, MSB first. The first data bit is driven on the sck_fall after bit 8.
  - en_fall in ADDR or DATA -> CHECK.
  - CHECK (1 cycle):
    - bit_cnt==16 and address < NREGS: for a write, register <= data; wr_strobe=1; wr_addr=address. A read has no side effect.
    - bit_cnt!=16 or address >= NREGS: frame_err=1, no write.
    - Next state is IDLE.
- Write latency: registers and wr_strobe update on the 2nd clk after en_fall is detected, i.e. SYNC_STAGES+2 clks after the pin falls.
- Simultaneous sck_rise and en_fall in the same cycle: the bit is captured first, then the frame is checked on that bit_cnt.
- en_rise while in CHECK is held pending and taken on the next cycle. No frame is lost with a minimum gap of 4 clk.
- spi_miso returns to 0 in IDLE and for write frames.
- Reset mid-frame: the frame is aborted, no write occurs, and no frame_err is asserted.
- Register bank is written only in CHECK. regs_flat is registered, with no combinational path from SPI pins.

Test Plan:
- Write frame 0x0281 (RW=0, addr 2, data 0x81) at clk/8 -> regs_flat[23:16]=0x81; wr_strobe pulses once with wr_addr=2; no other register changes.
- After the above, read frame 0x8200 -> spi_miso shifts 1000_0001 on bits 8..15; regs unchanged; no wr_strobe.
- Short frame of 12 bits, then en low -> no register change; frame_err pulses once.
- 17-bit frame, and a write to addr 9 (0x0955) -> frame_err each time, bank unchanged; a read of addr 9 returns 0x00 on miso and pulses frame_err.
- rst_n low after 10 bits of a write to addr 0 -> all outputs 0; the following valid write 0x0001 succeeds normally.
- Back-to-back writes 0x0011 and 0x0122 with a 4-clk gap, with en_fall coincident with the last sck_rise -> both registers written; two wr_strobe pulses.
